fust_s_table: RTL and testbench

- Issue-side scalar functional-unit status table; consumes the dispatch stage's scalar FUST row write (row, target FU, enable, operand tags).
- Tracks each scalar FU entry through operand wait, issue and execution.
- Returns per-entry state and contents to dispatch, raises issue requests to the scalar execute units, and clears operand tags on writeback.
- Sits between dispatch and scalar execute, driven by the same clock as the rest of the pipeline.

---
 rtl/fust_s_table.sv | 191 +++++++++++++++++++
 tb/tb_fust_s_table.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fust_s_table.sv
// fust_s_table -- scalar functional-unit status table.
//
// Holds one entry per scalar FU. Dispatch writes a row plus two source tags
// into a FREE entry. The entry waits for its tags to be cleared by writeback
// broadcasts, requests issue, and returns to FREE when its FU reports done.
//
// Ports:
//   CLK, nRST           clock (rising edge), asynchronous active-low reset
//   disp_en/fu/row/t1/t2 dispatch write: enable, target entry, payload, tags
//   wb_valid, wb_tag    writeback broadcast (tag 0 is ignored)
//   flush               squash WAIT/READY entries
//   iss_ready[i]        execute unit i accepts this cycle's issue request
//   fu_done[i]          execute unit i finished the issued op
//   iss_valid[i]        entry i is READY and requesting issue
//   row_o/t1_o/t2_o     stored per-entry contents
//   state_o             per-entry state (FREE=0 WAIT=1 READY=2 ISSUED=3)
//   busy_o              entry is not FREE
//   disp_reject         registered; last cycle's dispatch was refused

module fust_s_entry #(
  parameter int TAG_W = 2,
  parameter int ROW_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             alloc_i,
  input  logic [TAG_W-1:0] t1_i,
  input  logic [TAG_W-1:0] t2_i,
  input  logic [ROW_W-1:0] row_i,
  input  logic             wb_valid_i,
  input  logic [TAG_W-1:0] wb_tag_i,
  input  logic             flush_i,
  input  logic             iss_ready_i,
  input  logic             fu_done_i,
  output logic [1:0]       state_o,
  output logic [ROW_W-1:0] row_o,
  output logic [TAG_W-1:0] t1_o,
  output logic [TAG_W-1:0] t2_o
);
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    WAIT   = 2'd1,
    READY  = 2'd2,
    ISSUED = 2'd3
  } st_e;

  st_e              state_q, state_d;
  logic [TAG_W-1:0] t1_q, t1_d, t2_q, t2_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             wb_hit;
  logic [TAG_W-1:0] t1_clr, t2_clr;

  always_comb begin
    wb_hit  = wb_valid_i && (wb_tag_i != '0);
    // Stored tags after this cycle's wakeup; used for both the next-state
    // tag value and the WAIT->READY decision.
    t1_clr  = (wb_hit && t1_q == wb_tag_i) ? '0 : t1_q;
    t2_clr  = (wb_hit && t2_q == wb_tag_i) ? '0 : t2_q;
    state_d = state_q;
    t1_d    = t1_clr;
    t2_d    = t2_clr;
    row_d   = row_q;
    unique case (state_q)
      FREE: begin
        if (alloc_i) begin
          row_d   = row_i;
          t1_d    = t1_i;
          t2_d    = t2_i;
          state_d = (t1_i == '0 && t2_i == '0) ? READY : WAIT;
        end
      end
      WAIT: begin
        if (flush_i) begin
          state_d = FREE;
          t1_d    = '0;
          t2_d    = '0;
        end else if (t1_clr == '0 && t2_clr == '0) begin
          state_d = READY;
        end
      end
      READY: begin
        // An accepted issue is already in flight, so it beats flush.
        if (iss_ready_i) begin
          state_d = ISSUED;
        end else if (flush_i) begin
          state_d = FREE;
          t1_d    = '0;
          t2_d    = '0;
        end
      end
      ISSUED: begin
        if (fu_done_i) state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FREE;
      t1_q    <= '0;
      t2_q    <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      row_q   <= row_d;
    end
  end

  assign state_o = state_q;
  assign row_o   = row_q;
  assign t1_o    = t1_q;
  assign t2_o    = t2_q;
endmodule

module fust_s_table #(
  parameter int NUM_FU = 3,
  parameter int TAG_W  = 2,
  parameter int ROW_W  = 32,
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic                           disp_en,
  input  logic [FU_W-1:0]                disp_fu,
  input  logic [ROW_W-1:0]               disp_row,
  input  logic [TAG_W-1:0]               disp_t1,
  input  logic [TAG_W-1:0]               disp_t2,
  input  logic                           wb_valid,
  input  logic [TAG_W-1:0]               wb_tag,
  input  logic                           flush,
  input  logic [NUM_FU-1:0]              iss_ready,
  input  logic [NUM_FU-1:0]              fu_done,
  output logic [NUM_FU-1:0]              iss_valid,
  output logic [NUM_FU-1:0][ROW_W-1:0]   row_o,
  output logic [NUM_FU-1:0][TAG_W-1:0]   t1_o,
  output logic [NUM_FU-1:0][TAG_W-1:0]   t2_o,
  output logic [NUM_FU-1:0][1:0]         state_o,
  output logic [NUM_FU-1:0]              busy_o,
  output logic                           disp_reject
);
  logic             wb_hit;
  logic [TAG_W-1:0] t1_eff, t2_eff;
  logic [NUM_FU-1:0] alloc;
  logic             reject_d, reject_q;

  // Same-cycle bypass: a tag being written back right now is already ready.
  assign wb_hit = wb_valid && (wb_tag != '0);
  assign t1_eff = (wb_hit && disp_t1 == wb_tag) ? '0 : disp_t1;
  assign t2_eff = (wb_hit && disp_t2 == wb_tag) ? '0 : disp_t2;

  // Allocation decoded per entry so an out-of-range index matches nothing
  // and simply falls through to a reject. An entry finishing this cycle is
  // still ISSUED here, so a colliding dispatch is refused.
  always_comb begin
    alloc = '0;
    for (int i = 0; i < NUM_FU; i++)
      alloc[i] = disp_en && !flush && (disp_fu == FU_W'(i)) && !busy_o[i];
    reject_d = disp_en && !flush && (alloc == '0);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) reject_q <= 1'b0;
    else       reject_q <= reject_d;
  end
  assign disp_reject = reject_q;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_ent
    fust_s_entry #(.TAG_W(TAG_W), .ROW_W(ROW_W)) u_ent (
      .clk_i       (CLK),
      .rst_ni      (nRST),
      .alloc_i     (alloc[g]),
      .t1_i        (t1_eff),
      .t2_i        (t2_eff),
      .row_i       (disp_row),
      .wb_valid_i  (wb_valid),
      .wb_tag_i    (wb_tag),
      .flush_i     (flush),
      .iss_ready_i (iss_ready[g]),
      .fu_done_i   (fu_done[g]),
      .state_o     (state_o[g]),
      .row_o       (row_o[g]),
      .t1_o        (t1_o[g]),
      .t2_o        (t2_o[g])
    );
    assign iss_valid[g] = (state_o[g] == 2'd2);
    assign busy_o[g]    = (state_o[g] != 2'd0);
  end
endmodule

// File: tb/tb_fust_s_table.sv
module tb_fust_s_table;
  localparam int NUM_FU = 3;
  localparam int TAG_W  = 2;
  localparam int ROW_W  = 32;

  logic                         CLK = 1'b0;
  logic                         nRST = 1'b0;
  logic                         disp_en = 1'b0;
  logic [1:0]                   disp_fu = '0;
  logic [ROW_W-1:0]             disp_row = '0;
  logic [TAG_W-1:0]             disp_t1 = '0, disp_t2 = '0;
  logic                         wb_valid = 1'b0;
  logic [TAG_W-1:0]             wb_tag = '0;
  logic                         flush = 1'b0;
  logic [NUM_FU-1:0]            iss_ready = '0, fu_done = '0;
  logic [NUM_FU-1:0]            iss_valid, busy_o;
  logic [NUM_FU-1:0][ROW_W-1:0] row_o;
  logic [NUM_FU-1:0][TAG_W-1:0] t1_o, t2_o;
  logic [NUM_FU-1:0][1:0]       state_o;
  logic                         disp_reject;

  int total = 0;
  int bad = 0;

  fust_s_table #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .ROW_W(ROW_W)) dut (
    .CLK(CLK), .nRST(nRST), .disp_en(disp_en), .disp_fu(disp_fu),
    .disp_row(disp_row), .disp_t1(disp_t1), .disp_t2(disp_t2),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .flush(flush),
    .iss_ready(iss_ready), .fu_done(fu_done), .iss_valid(iss_valid),
    .row_o(row_o), .t1_o(t1_o), .t2_o(t2_o), .state_o(state_o),
    .busy_o(busy_o), .disp_reject(disp_reject)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic disp(input logic [1:0] fu, input logic [31:0] row,
                      input logic [1:0] t1, input logic [1:0] t2);
    disp_en = 1'b1; disp_fu = fu; disp_row = row; disp_t1 = t1; disp_t2 = t2;
  endtask

  task automatic idle();
    disp_en = 1'b0; wb_valid = 1'b0; wb_tag = '0; flush = 1'b0;
    iss_ready = '0; fu_done = '0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #12;
    total++;
    if (state_o !== '0 || row_o !== '0 || t1_o !== '0 || t2_o !== '0) begin
      bad++; $display("FAIL reset_contents state=%h row=%h t1=%h t2=%h want 0", state_o, row_o, t1_o, t2_o);
    end
    total++;
    if (iss_valid !== 3'b000 || busy_o !== 3'b000 || disp_reject !== 1'b0) begin
      bad++; $display("FAIL reset_flags iv=%b busy=%b rej=%b want 0", iss_valid, busy_o, disp_reject);
    end
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  task automatic test_basic();
    disp(2'd1, 32'hA5A5_0001, 2'd0, 2'd0);
    step(); idle();
    total++;
    if (state_o[1] !== 2'd2 || iss_valid !== 3'b010) begin
      bad++; $display("FAIL basic_ready state=%0d iv=%b want 2 010", state_o[1], iss_valid);
    end
    total++;
    if (row_o[1] !== 32'hA5A5_0001) begin
      bad++; $display("FAIL basic_row got=%h want a5a50001", row_o[1]);
    end
    iss_ready = 3'b010;
    step(); idle();
    total++;
    if (state_o[1] !== 2'd3 || iss_valid !== 3'b000) begin
      bad++; $display("FAIL basic_issued state=%0d iv=%b want 3 000", state_o[1], iss_valid);
    end
    fu_done = 3'b010;
    step(); idle();
    total++;
    if (state_o[1] !== 2'd0 || busy_o !== 3'b000) begin
      bad++; $display("FAIL basic_free state=%0d busy=%b want 0 000", state_o[1], busy_o);
    end
  endtask

  task automatic test_wakeup();
    disp(2'd0, 32'h1111_2222, 2'd2, 2'd3);
    step(); idle();
    total++;
    if (state_o[0] !== 2'd1 || t1_o[0] !== 2'd2 || t2_o[0] !== 2'd3) begin
      bad++; $display("FAIL wake_wait state=%0d t1=%0d t2=%0d want 1 2 3", state_o[0], t1_o[0], t2_o[0]);
    end
    wb_valid = 1'b1; wb_tag = 2'd2;
    step(); idle();
    total++;
    if (t1_o[0] !== 2'd0 || t2_o[0] !== 2'd3 || state_o[0] !== 2'd1) begin
      bad++; $display("FAIL wake_t1 t1=%0d t2=%0d state=%0d want 0 3 1", t1_o[0], t2_o[0], state_o[0]);
    end
    wb_valid = 1'b1; wb_tag = 2'd3;
    step(); idle();
    total++;
    if (state_o[0] !== 2'd2 || t2_o[0] !== 2'd0 || iss_valid !== 3'b001) begin
      bad++; $display("FAIL wake_ready state=%0d t2=%0d iv=%b want 2 0 001", state_o[0], t2_o[0], iss_valid);
    end
  endtask

  task automatic test_bypass();
    disp(2'd2, 32'h3333_4444, 2'd1, 2'd0);
    wb_valid = 1'b1; wb_tag = 2'd1;
    step(); idle();
    total++;
    if (state_o[2] !== 2'd2 || t1_o[2] !== 2'd0) begin
      bad++; $display("FAIL bypass state=%0d t1=%0d want 2 0", state_o[2], t1_o[2]);
    end
    flush = 1'b1;
    step(); idle();
    total++;
    if (busy_o !== 3'b000) begin
      bad++; $display("FAIL bypass_flush busy=%b want 000", busy_o);
    end
  endtask

  task automatic test_reject();
    disp(2'd1, 32'hCAFE_0001, 2'd0, 2'd0);
    step(); idle();
    iss_ready = 3'b010;
    step(); idle();
    disp(2'd1, 32'hDEAD_0002, 2'd0, 2'd0);
    step(); idle();
    total++;
    if (disp_reject !== 1'b1 || row_o[1] !== 32'hCAFE_0001 || state_o[1] !== 2'd3) begin
      bad++; $display("FAIL rej_issued rej=%b row=%h state=%0d want 1 cafe0001 3", disp_reject, row_o[1], state_o[1]);
    end
    step();
    total++;
    if (disp_reject !== 1'b0) begin
      bad++; $display("FAIL rej_pulse rej=%b want 0", disp_reject);
    end
    disp(2'd1, 32'hDEAD_0002, 2'd0, 2'd0);
    fu_done = 3'b010;
    step(); idle();
    total++;
    if (disp_reject !== 1'b1 || state_o[1] !== 2'd0 || row_o[1] !== 32'hCAFE_0001) begin
      bad++; $display("FAIL rej_done rej=%b state=%0d row=%h want 1 0 cafe0001", disp_reject, state_o[1], row_o[1]);
    end
    disp(2'd1, 32'hDEAD_0002, 2'd0, 2'd0);
    step(); idle();
    total++;
    if (disp_reject !== 1'b0 || state_o[1] !== 2'd2 || row_o[1] !== 32'hDEAD_0002) begin
      bad++; $display("FAIL rej_retry rej=%b state=%0d row=%h want 0 2 dead0002", disp_reject, state_o[1], row_o[1]);
    end
    disp(2'd3, 32'h0BAD_0003, 2'd0, 2'd0);
    step(); idle();
    total++;
    if (disp_reject !== 1'b1 || state_o[0] !== 2'd0 || state_o[2] !== 2'd0) begin
      bad++; $display("FAIL rej_range rej=%b s0=%0d s2=%0d want 1 0 0", disp_reject, state_o[0], state_o[2]);
    end
    flush = 1'b1;
    step(); idle();
  endtask

  task automatic test_flush();
    disp(2'd2, 32'h2222_0000, 2'd0, 2'd0);
    step(); idle();
    iss_ready = 3'b100;
    step(); idle();
    disp(2'd0, 32'h0000_0000, 2'd1, 2'd0);
    step(); idle();
    disp(2'd1, 32'h1111_0000, 2'd0, 2'd0);
    step(); idle();
    total++;
    if (state_o !== {2'd3, 2'd2, 2'd1}) begin
      bad++; $display("FAIL flush_setup state=%h want 39", state_o);
    end
    flush = 1'b1;
    step(); idle();
    total++;
    if (state_o !== {2'd3, 2'd0, 2'd0} || t1_o[0] !== 2'd0) begin
      bad++; $display("FAIL flush_states state=%h t1_0=%0d want 30 0", state_o, t1_o[0]);
    end
    fu_done = 3'b100;
    step(); idle();
    total++;
    if (state_o[2] !== 2'd0) begin
      bad++; $display("FAIL flush_done state=%0d want 0", state_o[2]);
    end
    disp(2'd0, 32'h5555_5555, 2'd0, 2'd0);
    flush = 1'b1;
    step(); idle();
    total++;
    if (state_o[0] !== 2'd0 || disp_reject !== 1'b0 || row_o[0] === 32'h5555_5555) begin
      bad++; $display("FAIL flush_disp state=%0d rej=%b row=%h want 0 0 not-55555555", state_o[0], disp_reject, row_o[0]);
    end
    disp(2'd1, 32'h7777_0000, 2'd0, 2'd0);
    step(); idle();
    flush = 1'b1; iss_ready = 3'b010;
    step(); idle();
    total++;
    if (state_o[1] !== 2'd3) begin
      bad++; $display("FAIL flush_vs_issue state=%0d want 3", state_o[1]);
    end
    fu_done = 3'b010;
    step(); idle();
  endtask

  task automatic test_async_reset();
    disp(2'd0, 32'h9999_8888, 2'd2, 2'd0);
    step(); idle();
    total++;
    if (state_o[0] !== 2'd1) begin
      bad++; $display("FAIL areset_pre state=%0d want 1", state_o[0]);
    end
    #2 nRST = 1'b0;
    #1;
    total++;
    if (state_o !== '0 || row_o !== '0 || t1_o !== '0 || busy_o !== 3'b000 || iss_valid !== 3'b000) begin
      bad++; $display("FAIL areset state=%h row=%h t1=%h busy=%b iv=%b want 0", state_o, row_o, t1_o, busy_o, iss_valid);
    end
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_reject();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
